analog_interface: RTL and testbench

- Capture controller for the digital oscilloscope. It sits between the ADC sample strobe and the 512-entry sample RAM.
- Decimates the ADC sample stream and writes samples into a circular RAM.
- Arms once the pre-trigger history is full, detects the configured trigger edge, and captures trig_pos post-trigger samples.
- Flags completion to the command/config block.

---
 rtl/analog_interface_pkg.sv | 31 +++
 rtl/analog_interface_trig_detect.sv | 38 +++
 rtl/analog_interface.sv | 213 +++++++++++++++++++++
 tb/tb_analog_interface.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_interface_pkg.sv
// analog_interface_pkg: shared types and constants for the oscilloscope
// capture controller (state encoding, trig_cfg field layout, trigger modes).
package analog_interface_pkg;

    localparam int unsigned DEPTH        = 512;
    localparam int unsigned ADDR_W       = 9;
    localparam int unsigned AUTO_TIMEOUT = 65536;

    // trig_cfg field positions
    localparam int unsigned CFG_EDGE    = 4;
    localparam int unsigned CFG_MODE_HI = 3;
    localparam int unsigned CFG_MODE_LO = 2;
    localparam int unsigned CFG_SRC_HI  = 1;
    localparam int unsigned CFG_SRC_LO  = 0;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_NORMAL  = 2'b01,
        MODE_AUTO    = 2'b10,
        MODE_NORMAL2 = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/analog_interface_trig_detect.sv
// trig_detect: selects the trigger comparator, synchronizes it into the clk
// domain with two flops and flags the configured edge for one clk.
module trig_detect
    import analog_interface_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       trig1,
    input  logic       trig2,
    input  logic [1:0] src,
    input  logic       edge_rise,
    output logic       trig_evt
);

    logic sel;
    logic sync1;
    logic sync2;
    logic prev;

    // source 01 picks trig2, every other code falls back to trig1
    assign sel = (src == 2'b01) ? trig2 : trig1;

    // two-flop synchronizer followed by the edge history register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sel;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign trig_evt = edge_rise ? (sync2 & ~prev) : (~sync2 & prev);

endmodule

// File: rtl/analog_interface.sv
// analog_interface: oscilloscope capture controller. Decimates the ADC sample
// strobe, writes samples into a circular 512-entry RAM, arms once pre-trigger
// history is full, captures trig_pos post-trigger samples and pulses
// set_cap_done. Define AUTO_TRIG_EN to let mode 10 force a trigger after
// AUTO_TIMEOUT sample ticks in ARMED.
module analog_interface
    import analog_interface_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_clk,
    input  logic              trig1,
    input  logic              trig2,
    input  logic [3:0]        decimator,
    input  logic [7:0]        trig_cfg,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              trig_en,
    output logic              set_cap_done,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] trace_end,
    output logic              armed,
    output logic              triggered
);

    state_t              state;
    state_t              state_nxt;
    mode_t               mode;
    logic                run_ok;
    logic                active;

    logic                prev_adc;
    logic                tick;
    logic [15:0]         dec_cnt;
    logic [3:0]          dec_lim;
    logic [15:0]         dec_mask;
    logic                wr_tick;

    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W:0]     cnt;
    logic [ADDR_W:0]     fill_target;
    logic [ADDR_W-1:0]   end_addr;

    logic                trig_evt;
    logic                auto_fire;
    logic                do_write;
    logic                done_now;
    logic                clr_cnt;
    logic                unused_cfg;

    assign unused_cfg = ^trig_cfg[7:5];

    assign mode   = mode_t'(trig_cfg[CFG_MODE_HI:CFG_MODE_LO]);
    assign run_ok = trig_en && (mode != MODE_OFF);
    assign active = (state == FILL) || (state == ARMED) || (state == POST);

    assign tick     = adc_clk & ~prev_adc;
    assign dec_mask = (16'd1 << dec_lim) - 16'd1;
    assign wr_tick  = tick && (dec_cnt == dec_mask);

    assign fill_target = (trig_pos == '0) ? 10'd512 : 10'd512 - {1'b0, trig_pos};
    assign end_addr    = (trig_pos == '0) ? wptr - 9'd1 : wptr;

    assign armed     = (state == ARMED);
    assign triggered = (state == POST);

    trig_detect u_trig_detect (
        .clk       (clk),
        .rst       (rst),
        .trig1     (trig1),
        .trig2     (trig2),
        .src       (trig_cfg[CFG_SRC_HI:CFG_SRC_LO]),
        .edge_rise (trig_cfg[CFG_EDGE]),
        .trig_evt  (trig_evt)
    );

`ifdef AUTO_TRIG_EN
    logic [16:0] auto_cnt;

    // sample ticks spent in ARMED without an accepted trigger
    always_ff @(posedge clk) begin
        if (rst || state != ARMED) begin
            auto_cnt <= '0;
        end else if (tick) begin
            auto_cnt <= auto_cnt + 17'd1;
        end
    end

    assign auto_fire = (state == ARMED) && (mode == MODE_AUTO) && tick &&
                       (auto_cnt == 17'(AUTO_TIMEOUT - 1));
`else
    assign auto_fire = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and per-cycle write/completion strobes
    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        done_now  = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (run_ok) begin
                    state_nxt = FILL;
                    clr_cnt   = 1'b1;
                end
            end
            FILL: begin
                if (!run_ok) begin
                    state_nxt = IDLE;
                end else if (wr_tick) begin
                    do_write = 1'b1;
                    if (cnt + 10'd1 == fill_target) begin
                        state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                if (!run_ok) begin
                    state_nxt = IDLE;
                end else begin
                    do_write = wr_tick;
                    if (trig_evt || auto_fire) begin
                        state_nxt = POST;
                        clr_cnt   = 1'b1;
                    end
                end
            end
            POST: begin
                if (!run_ok) begin
                    state_nxt = IDLE;
                end else if (trig_pos == '0) begin
                    // no post-trigger samples: finish right away, no write
                    done_now  = 1'b1;
                    state_nxt = DONE;
                end else if (wr_tick) begin
                    do_write = 1'b1;
                    if (cnt + 10'd1 == {1'b0, trig_pos}) begin
                        done_now  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!trig_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sample tick, decimation, write pointer, RAM strobes and capture result
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_adc     <= 1'b0;
            dec_cnt      <= '0;
            dec_lim      <= '0;
            wptr         <= '0;
            cnt          <= '0;
            en           <= 1'b0;
            we           <= 1'b0;
            addr         <= '0;
            trace_end    <= '0;
            set_cap_done <= 1'b0;
        end else begin
            prev_adc     <= adc_clk;
            en           <= do_write;
            we           <= do_write;
            set_cap_done <= done_now;

            if (do_write) begin
                addr <= wptr;
                wptr <= wptr + 9'd1;
            end

            if (done_now) begin
                trace_end <= end_addr;
            end

            // counter is reused: pre-trigger writes in FILL, post writes in POST
            if (clr_cnt) begin
                cnt <= '0;
            end else if (do_write) begin
                cnt <= cnt + 10'd1;
            end

            // decimator is sampled only when the counter clears
            if (!active) begin
                dec_cnt <= '0;
                dec_lim <= decimator;
            end else if (tick) begin
                if (dec_cnt == dec_mask) begin
                    dec_cnt <= '0;
                    dec_lim <= decimator;
                end else begin
                    dec_cnt <= dec_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_analog_interface.sv
// tb_analog_interface: randomized capture runs with a scoreboard. The stimulus
// side predicts every RAM write address and every trace_end; a monitor pops
// and compares whenever the DUT strobes en or set_cap_done.
module tb_analog_interface;

    logic       clk = 1'b0;
    logic       rst;
    logic       adc_clk;
    logic       trig1;
    logic       trig2;
    logic [3:0] decimator;
    logic [7:0] trig_cfg;
    logic [8:0] trig_pos;
    logic       trig_en;
    logic       set_cap_done;
    logic       en;
    logic       we;
    logic [8:0] addr;
    logic [8:0] trace_end;
    logic       armed;
    logic       triggered;

    int checks   = 0;
    int failures = 0;

    int unsigned exp_addr_q[$];
    int unsigned exp_end_q[$];
    int unsigned m_wptr     = 0;
    int unsigned m_ticks    = 0;
    int unsigned m_last_end = 0;

    always #5 clk = ~clk;

    analog_interface dut (
        .clk          (clk),
        .rst          (rst),
        .adc_clk      (adc_clk),
        .trig1        (trig1),
        .trig2        (trig2),
        .decimator    (decimator),
        .trig_cfg     (trig_cfg),
        .trig_pos     (trig_pos),
        .trig_en      (trig_en),
        .set_cap_done (set_cap_done),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .trace_end    (trace_end),
        .armed        (armed),
        .triggered    (triggered)
    );

    function automatic void check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // every 2^decimator-th sample of a capture is stored
    function automatic bit will_write();
        int unsigned period;
        period = 32'd1 << decimator;
        return (m_ticks % period) == (period - 1);
    endfunction

    task automatic tick(output bit wrote);
        wrote = will_write();
        if (wrote) begin
            exp_addr_q.push_back(m_wptr);
            m_wptr = (m_wptr + 1) % 512;
        end
        m_ticks++;
        adc_clk = 1'b1;
        wait_clks($urandom_range(1, 2));
        adc_clk = 1'b0;
        wait_clks($urandom_range(1, 2));
    endtask

    task automatic raw_tick();
        adc_clk = 1'b1;
        wait_clks(2);
        adc_clk = 1'b0;
        wait_clks(2);
    endtask

    task automatic set_line(input logic [1:0] src, input logic v);
        if (src == 2'b01) trig2 = v;
        else              trig1 = v;
    endtask

    task automatic capture(input logic [3:0] dec, input logic [1:0] src, input bit rise,
                           input logic [1:0] mode, input int unsigned tp, input bit abort);
        int unsigned n_fill;
        int unsigned writes;
        int unsigned n_post;
        bit w;
        n_fill    = (tp == 0) ? 512 : 512 - tp;
        decimator = dec;
        trig_cfg  = {3'($urandom), rise, mode, src};
        trig_pos  = 9'(tp);
        trig_en   = 1'b1;
        m_ticks   = 0;
        wait_clks(1);
        check("armed_at_fill_start", armed, 0);

        writes = 0;
        while (writes < n_fill) begin
            tick(w);
            if (w) writes++;
            check("armed_during_fill", armed, (writes == n_fill) ? 1 : 0);
        end

        if (src == 2'b01) begin
            trig1 = 1'b1;
            wait_clks(5);
            trig1 = 1'b0;
            wait_clks(5);
            check("trig1_ignored_src2", triggered, 0);
        end
        if (!rise) begin
            set_line(src, 1'b1);
            wait_clks(5);
            check("rising_ignored", triggered, 0);
        end
        check("armed_before_trigger", armed, 1);

        if (tp == 0) exp_end_q.push_back((m_wptr + 511) % 512);
        set_line(src, rise);
        wait_clks(2);
        check("trigger_latency_early", triggered, 0);
        wait_clks(1);
        check("triggered", triggered, 1);
        check("armed_cleared", armed, 0);

        if (tp == 0) begin
            wait_clks(1);
            m_last_end = (m_wptr + 511) % 512;
        end else begin
            n_post = abort ? 3 : tp;
            writes = 0;
            while (writes < n_post) begin
                if (!abort && writes + 1 == tp && will_write())
                    exp_end_q.push_back(m_wptr);
                tick(w);
                if (w) begin
                    writes++;
                    if (!abort && writes == tp) m_last_end = (m_wptr + 511) % 512;
                end
            end
            if (abort) begin
                check("still_triggered", triggered, 1);
                trig_en = 1'b0;
                wait_clks(2);
            end
        end
        check("triggered_cleared", triggered, 0);
        check("armed_idle", armed, 0);
        check("trace_end_value", trace_end, m_last_end);

        if (!abort) begin
            raw_tick();
            raw_tick();
            check("no_write_in_done", en, 0);
        end

        trig_en = 1'b0;
        trig1   = 1'b0;
        trig2   = 1'b0;
        wait_clks(6);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (en || we) begin
                check("we_equals_en", we, en);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr=%0d, no write expected at %0t", addr, $time);
                end else begin
                    check("write_addr", addr, exp_addr_q.pop_front());
                end
            end
            if (set_cap_done) begin
                if (exp_end_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: trace_end=%0d, no completion expected at %0t", trace_end, $time);
                end else begin
                    check("done_trace_end", trace_end, exp_end_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        adc_clk   = 1'b0;
        trig1     = 1'b0;
        trig2     = 1'b0;
        trig_en   = 1'b0;
        decimator = '0;
        trig_cfg  = '0;
        trig_pos  = '0;
        wait_clks(3);
        check("reset_set_cap_done", set_cap_done, 0);
        check("reset_en", en, 0);
        check("reset_we", we, 0);
        check("reset_addr", addr, 0);
        check("reset_trace_end", trace_end, 0);
        check("reset_armed", armed, 0);
        check("reset_triggered", triggered, 0);
        rst = 1'b0;
        wait_clks(2);

        // mode off keeps the controller idle
        trig_cfg = 8'h10;
        trig_en  = 1'b1;
        raw_tick();
        raw_tick();
        check("mode_off_idle", armed, 0);
        trig_en = 1'b0;
        wait_clks(2);

        capture(4'd2, 2'b00, 1'b1, 2'b01, 9'h0A1, 1'b0);
        capture(4'd0, 2'b01, 1'b1, 2'b01, $urandom_range(1, 511), 1'b0);
        capture(4'd1, 2'b00, 1'b0, 2'b11, $urandom_range(1, 511), 1'b0);
        capture(4'd0, 2'b00, 1'b1, 2'b01, 0, 1'b0);
        capture(4'd0, 2'b10, 1'b1, 2'b01, 100, 1'b1);
        capture(4'd0, 2'b00, 1'b1, 2'b10, $urandom_range(0, 511), 1'b0);
        for (int i = 0; i < 4; i++) begin
            capture(4'($urandom_range(0, 1)), 2'($urandom), 1'($urandom),
                    2'($urandom_range(1, 3)), $urandom_range(0, 511), 1'b0);
        end

        wait_clks(4);
        check("addr_queue_drained", exp_addr_q.size(), 0);
        check("end_queue_drained", exp_end_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
